// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
//   Shared types for the sequential radix-2 Booth multiplier:
//     state_t : control FSM states (IDLE, RUN, DONE)
//     op_t    : per-step Booth operation (NOP, ADD, SUB)
//     booth_decode() : maps the {Q[0], Q-1} bit pair onto an op_t
// ----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } op_t;

    // Radix-2 Booth recoding: 10 starts a run of ones (subtract),
    // 01 ends one (add), 00/11 are inside a run (nothing to do).
    function automatic op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b10:   return SUB;
            2'b01:   return ADD;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// ----------------------------------------------------------------------------
// booth_addsub
//   Combinational add/subtract stage of the Booth multiplier.
//   Ports:
//     op     in  op_t   NOP / ADD / SUB
//     a      in  W      current partial product (accumulator A)
//     m      in  W      sign-extended multiplicand
//     result out W      a, a+m or a-m according to op
// ----------------------------------------------------------------------------
module booth_addsub
    import booth_pkg::*;
#(
    parameter int W = 5
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic [W-1:0] result
);

    always_comb begin
        case (op)
            ADD:     result = a + m;
            SUB:     result = a - m;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// ----------------------------------------------------------------------------
// booth_mul_seq
//   Sequential radix-2 Booth signed multiplier with its own control FSM.
//   One Booth step per RUN cycle; the 2N-bit product is {A[N-1:0], Q}.
//
//   Optional feature macro: BOOTH_EARLY_TERM_EN
//     When defined, RUN finishes as soon as the multiplier bits still to be
//     scanned (Q[count-1:0] and Q-1) are uniform: the remaining shifts are
//     applied in one arithmetic shift by count. When undefined, latency is
//     a fixed N steps and no barrel shifter exists.
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous active-low reset
//     start  in   1      start request, accepted in IDLE or DONE
//     Min    in   N      signed multiplicand, latched on accept
//     Q      in   N      signed multiplier, latched on accept
//     busy   out  1      high while in RUN
//     done   out  1      one-cycle pulse, Dout valid
//     count  out  CNT_W  remaining Booth steps
//     Dout   out  2N     product {A[N-1:0], Q}, held until next accept
// ----------------------------------------------------------------------------
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     Min,
    input  logic [N-1:0]     Q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [2*N-1:0]   Dout
);

    state_t           state, state_next;
    logic [N:0]       a_r;      // one guard bit so M = -2^(N-1) cannot overflow
    logic [N-1:0]     q_r;
    logic             qm1_r;
    logic [N-1:0]     m_r;
    logic [CNT_W-1:0] count_r;

    logic [N:0]       a_sum;
    logic [N:0]       a_nxt;
    logic [N-1:0]     q_nxt;
    logic             qm1_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             early_term;
    logic             accept;
    logic             last_step;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (count_r == CNT_W'(1)) || early_term;

    booth_addsub #(.W(N + 1)) u_addsub (
        .op     (booth_decode(q_r[0], qm1_r)),
        .a      (a_r),
        .m      ({m_r[N-1], m_r}),
        .result (a_sum)
    );

    // ------------------------------------------------------------------
    // Step datapath: one add/sub plus a 1-bit arithmetic shift of
    // {A,Q,Q-1}, or (early termination) a shift of {A,Q} by count.
    // ------------------------------------------------------------------
`ifdef BOOTH_EARLY_TERM_EN
    logic             all_zero;
    logic             all_one;
    logic [2*N:0]     aq_shifted;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        all_zero = ~qm1_r;
        all_one  = qm1_r;
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < count_r) begin
                all_zero = all_zero & ~q_r[i];
                all_one  = all_one  &  q_r[i];
            end
        end
        early_term = all_zero | all_one;
        aq_shifted = $signed({a_r, q_r}) >>> count_r;
    end
`else
    assign early_term = 1'b0;
`endif

    always_comb begin
        a_nxt     = {a_sum[N], a_sum[N:1]};
        q_nxt     = {a_sum[0], q_r[N-1:1]};
        qm1_nxt   = q_r[0];
        count_nxt = count_r - CNT_W'(1);
`ifdef BOOTH_EARLY_TERM_EN
        if (early_term) begin
            // Remaining steps are all NOPs; Q-1 already holds the
            // uniform bit value, so it stays as it is.
            {a_nxt, q_nxt} = aq_shifted;
            qm1_nxt        = qm1_r;
            count_nxt      = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / shift registers and step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            a_r     <= '0;
            q_r     <= '0;
            qm1_r   <= 1'b0;
            m_r     <= '0;
            count_r <= '0;
        end else if (accept) begin
            a_r     <= '0;
            q_r     <= Q;
            qm1_r   <= 1'b0;
            m_r     <= Min;
            count_r <= CNT_W'(N);
        end else if (state == RUN) begin
            a_r     <= a_nxt;
            q_r     <= q_nxt;
            qm1_r   <= qm1_nxt;
            count_r <= count_nxt;
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign count = count_r;
    assign Dout  = {a_r[N-1:0], q_r};

endmodule

// File: tb/tb_booth_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_booth_mul_seq
//   Self-checking bench for booth_mul_seq: an N=4 instance for directed,
//   abort, back-to-back and random cases, and an N=8 instance for a random
//   sweep. Expected products come from plain signed multiplication and
//   expected latency from scanning the multiplier bits.
// ----------------------------------------------------------------------------
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N = 4 instance
    logic       start4;
    logic [3:0] min4, q4;
    logic       busy4, done4;
    logic [2:0] count4;
    logic [7:0] dout4;

    // N = 8 instance
    logic        start8;
    logic [7:0]  min8, q8;
    logic        busy8, done8;
    logic [3:0]  count8;
    logic [15:0] dout8;

    int n_checks = 0;
    int n_fail   = 0;

    booth_mul_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .Min(min4), .Q(q4),
        .busy(busy4), .done(done4), .count(count4), .Dout(dout4)
    );

    booth_mul_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .Min(min8), .Q(q8),
        .busy(busy8), .done(done8), .count(count8), .Dout(dout8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signed n-bit x n-bit product, truncated to 2n bits.
    function automatic logic [15:0] prod_model(input int n, input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (a[n-1]) sa = sa - (longint'(1) << n);
        if (b[n-1]) sb = sb - (longint'(1) << n);
        p = sa * sb;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    // Clock edges from the accepting edge until done is visible.
    function automatic int lat_model(input int n, input logic [7:0] qv);
`ifdef BOOTH_EARLY_TERM_EN
        logic prev;
        bit   uni;
        for (int j = 0; j < n; j++) begin
            prev = (j == 0) ? 1'b0 : qv[j-1];
            uni  = 1'b1;
            for (int b = j; b < n; b++)
                if (qv[b] != prev) uni = 1'b0;
            if (uni) return j + 1;
        end
`endif
        return n;
    endfunction

    // One N=4 operation. poke_start pulses start during the second RUN cycle.
    task automatic run4(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                        input string tag, input bit poke_start);
        int e;
        int lat;
        logic [7:0] held;
        lat = lat_model(4, {4'b0, q});
        @(negedge clk);
        start4 = 1'b1; min4 = m; q4 = q;
        @(negedge clk);
        start4 = 1'b0; min4 = 4'($urandom); q4 = 4'($urandom);
        check({tag, " busy"}, 64'(busy4), 64'd1);
        check({tag, " count@accept"}, 64'(count4), 64'd4);
        e = 0;
        while (!done4 && e < 50) begin
            @(negedge clk);
            e++;
            start4 = (poke_start && e == 1);
        end
        start4 = 1'b0;
        check({tag, " latency"}, 64'(e), 64'(lat));
        check({tag, " product"}, 64'(dout4), 64'(exp));
        check({tag, " count@done"}, 64'(count4), 64'd0);
        check({tag, " busy@done"}, 64'(busy4), 64'd0);
        held = dout4;
        repeat (3) begin
            @(negedge clk);
            check({tag, " done pulse"}, 64'(done4), 64'd0);
            check({tag, " held"}, 64'(dout4), 64'(held));
        end
    endtask

    task automatic run8(input logic [7:0] m, input logic [7:0] q, input string tag);
        int e;
        @(negedge clk);
        start8 = 1'b1; min8 = m; q8 = q;
        @(negedge clk);
        start8 = 1'b0; min8 = 8'($urandom); q8 = 8'($urandom);
        e = 0;
        while (!done8 && e < 50) begin
            @(negedge clk);
            e++;
        end
        check({tag, " latency"}, 64'(e), 64'(lat_model(8, q)));
        check({tag, " product"}, 64'(dout8), 64'(prod_model(8, m, q)));
    endtask

    logic [3:0] dm [6];
    logic [3:0] dq [6];
    logic [7:0] dp [6];
    logic [3:0] bm [4];
    logic [3:0] bq [4];

    initial begin
        int e;
        logic [3:0] rm, rq;

        rst = 1'b0;
        start4 = 1'b0; min4 = '0; q4 = '0;
        start8 = 1'b0; min8 = '0; q8 = '0;
        repeat (2) @(negedge clk);
        check("reset dout", 64'(dout4), 64'd0);
        check("reset count", 64'(count4), 64'd0);
        check("reset busy", 64'(busy4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        rst = 1'b1;

        // Directed products, including the -2^(N-1) corners and the
        // early-termination cases (0 and -1 multipliers).
        dm[0] = 4'd3;  dq[0] = 4'hE; dp[0] = 8'hFA;
        dm[1] = 4'h8;  dq[1] = 4'h8; dp[1] = 8'h40;
        dm[2] = 4'h8;  dq[2] = 4'd7; dp[2] = 8'hC8;
        dm[3] = 4'd7;  dq[3] = 4'd7; dp[3] = 8'h31;
        dm[4] = 4'd5;  dq[4] = 4'd0; dp[4] = 8'h00;
        dm[5] = 4'd5;  dq[5] = 4'hF; dp[5] = 8'hFB;
        for (int i = 0; i < 6; i++)
            run4(dm[i], dq[i], dp[i], $sformatf("dir%0d", i), 1'b0);

        // start pulsed during RUN is ignored
        run4(4'd3, 4'hE, 8'hFA, "poke", 1'b1);

        // Reset in the middle of RUN aborts at once
        @(negedge clk);
        start4 = 1'b1; min4 = 4'd3; q4 = 4'hE;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort dout", 64'(dout4), 64'd0);
        check("abort count", 64'(count4), 64'd0);
        check("abort busy", 64'(busy4), 64'd0);
        check("abort done", 64'(done4), 64'd0);
        @(negedge clk);
        check("abort no done", 64'(done4), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort idle done", 64'(done4), 64'd0);
        run4(4'hD, 4'd5, 8'hF1, "after abort", 1'b0);

        // Back-to-back with start held high
        bm[0] = 4'd2;  bq[0] = 4'd3;
        bm[1] = 4'hB;  bq[1] = 4'd6;
        bm[2] = 4'h8;  bq[2] = 4'hF;
        bm[3] = 4'd7;  bq[3] = 4'h9;
        @(negedge clk);
        start4 = 1'b1; min4 = bm[0]; q4 = bq[0];
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                min4 = bm[i+1]; q4 = bq[i+1];
            end else begin
                start4 = 1'b0;
            end
            e = 0;
            while (!done4 && e < 50) begin
                @(negedge clk);
                e++;
            end
            check($sformatf("b2b%0d latency", i), 64'(e), 64'(lat_model(4, {4'b0, bq[i]})));
            check($sformatf("b2b%0d product", i), 64'(dout4),
                  64'(prod_model(4, {4'b0, bm[i]}, {4'b0, bq[i]})));
            if (i < 3) @(posedge clk);
        end
        @(negedge clk);
        check("b2b final idle", 64'(busy4), 64'd0);

        // Random sweeps
        for (int i = 0; i < 20; i++) begin
            rm = 4'($urandom);
            rq = 4'($urandom);
            run4(rm, rq, 8'(prod_model(4, {4'b0, rm}, {4'b0, rq})),
                 $sformatf("rnd4_%0d", i), 1'b0);
        end
        for (int i = 0; i < 30; i++)
            run8(8'($urandom), 8'($urandom), $sformatf("rnd8_%0d", i));
        run8(8'h80, 8'h80, "rnd8 minmin");
        run8(8'h80, 8'h7F, "rnd8 minmax");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
